mux_8x1_rr_arbiter: RTL

Round-robin arbiter that shares the single-bit 8:1 selection channel between eight requesters. It registers a one-hot grant and the matching 3-bit select, and gates the selected input bit onto the shared output. Grant tenure is bounded by a programmable burst limit so that no requester can starve the others. It sits directly in front of the 8:1 mux and is the only driver of its select.

---
 rtl/mux_8x1_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter owning the select of a single-bit 8:1 mux; grant tenure capped at MAX_BURST cycles.
// Latency: req sampled at a rising edge is granted at that edge (registered gnt/sel/gnt_valid); out is combinational.
// Backpressure: requesters hold req high until served; the holder yields on release or burst expiry.
module mux_8x1_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_e;

  // Last burst_cnt value a tenure may reach before it is forced to re-arbitrate.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0] req_excl;
  logic       win_any, win_excl_any;
  logic [2:0] win_idx, win_excl_idx;

  // Round-robin search from last+1 around to last; scanning the offsets downward lets the nearest requester win.
  // A second search excludes the current holder for the burst-expiry case.
  always_comb begin
    req_excl     = req & ~(8'b1 << sel_q);
    win_any      = 1'b0;
    win_idx      = 3'd0;
    win_excl_any = 1'b0;
    win_excl_idx = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      if (req[last_q + 3'(i)]) begin
        win_any = 1'b1;
        win_idx = last_q + 3'(i);
      end
      if (req_excl[last_q + 3'(i)]) begin
        win_excl_any = 1'b1;
        win_excl_idx = last_q + 3'(i);
      end
    end
  end

  // Next-state logic: grant, hold, hand over on release/expiry, or fall back to IDLE.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d     = GRANT;
          gnt_d       = 8'b1 << win_idx;
          sel_d       = win_idx;
          gnt_valid_d = 1'b1;
          last_d      = win_idx;
          cnt_d       = 8'd0;
        end
      end
      GRANT: begin
        if (req[sel_q] && (cnt_q < BURST_LAST)) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!req[sel_q]) begin
          // Holder released: the holder's bit is already clear, so the full search hands over directly.
          if (win_any) begin
            gnt_d  = 8'b1 << win_idx;
            sel_d  = win_idx;
            last_d = win_idx;
            cnt_d  = 8'd0;
          end else begin
            state_d     = IDLE;
            gnt_d       = 8'd0;
            gnt_valid_d = 1'b0;
            cnt_d       = 8'd0;
          end
        end else begin
          // Burst expired: pass to someone else if anyone waits, otherwise start a fresh tenure for the holder.
          if (win_excl_any) begin
            gnt_d  = 8'b1 << win_excl_idx;
            sel_d  = win_excl_idx;
            last_d = win_excl_idx;
          end
          cnt_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset parks the pointer at 7 so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 8'd0;
      sel_q       <= 3'd0;
      gnt_valid_q <= 1'b0;
      last_q      <= 3'd7;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign out       = in[sel_q] & gnt_valid_q;

endmodule
